// File: rtl/ecall_pkg.sv
// Shared types and constants for the decode-stage ecall sequencer.
package ecall_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } ecall_state_t;

    localparam logic [4:0]  A7_REG_IDX      = 5'd17;
    localparam logic [31:0] ECALL_HALT_CODE = 32'd10;

endpackage

// File: rtl/ecall_hazard_check.sv
// Combinational check: is the a7 producer of an ecall in ID still unforwardable?
module ecall_hazard_check
    import ecall_pkg::*;
#(
    parameter logic [4:0] A7_REG = A7_REG_IDX
) (
    input  logic       i_is_ecall,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_ex_rd,
    input  logic       i_id_ex_reg_write,
    input  logic [4:0] i_ex_mem_rd,
    input  logic       i_ex_mem_reg_write,
    input  logic       i_ex_mem_mem_read,
    output logic       o_ecall_hazard
);

    logic w_h_ex;
    logic w_h_mem;

    // EX result is not yet in EX/MEM; a load in MEM has no ALU-side data to forward
    assign w_h_ex  = i_id_ex_reg_write & (i_id_ex_rd == A7_REG);
    assign w_h_mem = i_ex_mem_reg_write & i_ex_mem_mem_read & (i_ex_mem_rd == A7_REG);

    assign o_ecall_hazard = i_is_ecall & i_id_valid & (w_h_ex | w_h_mem);

endmodule

// File: rtl/ecall_halt_unit.sv
// Ecall sequencer: stalls on an unready a7, detects halt (a7 == HALT_CODE),
// freezes fetch, drains older instructions, then raises sticky is_halted.
module ecall_halt_unit
    import ecall_pkg::*;
#(
    parameter logic [4:0]  A7_REG       = A7_REG_IDX,
    parameter logic [31:0] HALT_CODE    = ECALL_HALT_CODE,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_ecall,
    input  logic        id_valid,
    input  logic [4:0]  ID_EX_rd,
    input  logic        ID_EX_reg_write,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        EX_MEM_reg_write,
    input  logic        EX_MEM_mem_read,
    input  logic [31:0] a7_value,
    output logic        ecall_stall,
    output logic        halt_flush,
    output logic        is_halted
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    ecall_state_t r_state;
    ecall_state_t w_state_next;
    logic [2:0]   r_drain_cnt;
    logic [2:0]   w_drain_cnt_next;
    logic         r_is_halted;
    logic         w_hazard;
    logic         w_halt_detect;

    ecall_hazard_check #(
        .A7_REG (A7_REG)
    ) u_hazard (
        .i_is_ecall         (is_ecall),
        .i_id_valid         (id_valid),
        .i_id_ex_rd         (ID_EX_rd),
        .i_id_ex_reg_write  (ID_EX_reg_write),
        .i_ex_mem_rd        (EX_MEM_rd),
        .i_ex_mem_reg_write (EX_MEM_reg_write),
        .i_ex_mem_mem_read  (EX_MEM_mem_read),
        .o_ecall_hazard     (w_hazard)
    );

    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        w_halt_detect    = 1'b0;
        ecall_stall      = 1'b0;
        halt_flush       = 1'b0;
        case (r_state)
            RUN: begin
                ecall_stall   = w_hazard;
                w_halt_detect = is_ecall & id_valid & ~w_hazard & (a7_value == HALT_CODE);
                halt_flush    = w_halt_detect;
                if (w_halt_detect) begin
                    w_state_next     = DRAIN;
                    w_drain_cnt_next = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                halt_flush = 1'b1;
                if (r_drain_cnt == 3'd0) begin
                    w_state_next = HALTED;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - 3'd1;
                end
            end
            HALTED: begin
                halt_flush = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
            r_is_halted <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
            if (w_state_next == HALTED) begin
                r_is_halted <= 1'b1;
            end
        end
    end

    assign is_halted = r_is_halted;

endmodule
